// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM encoding, requester IDs
// and default widths.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_UPG = 1'b1
    } req_id_e;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_LAT = 1;

endpackage

// File: rtl/dmem_arb_wbuf.sv
// One-entry holding buffer for UART loader writes; the loader never waits, so a
// write arriving while the entry is occupied and not leaving is lost and flagged.
module dmem_arb_wbuf
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdat,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] dat,
    output logic              ovf
);

    logic load;
    logic drop;

    // An entry being granted this cycle frees the slot in time for a new load.
    assign load = wen & (~full | drain);
    assign drop = wen & full & ~drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            full <= load | (full & ~drain);
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            adr <= wadr;
            dat <= wdat;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data BRAM between the MEM stage and the UART loader
// with round-robin arbitration. Optional statistics: define DMEM_ARB_STATS_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_misalign,
    input  logic              upg_active,
    input  logic              upg_wen,
    input  logic [ADDR_W-1:0] upg_adr,
    input  logic [DATA_W-1:0] upg_dat,
    output logic              upg_ovf,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       stat_stall_cyc,
    output logic [15:0]       stat_conflicts,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_e        state, state_nxt;
    req_id_e           last_grant;
    req_id_e           issue_req_p1;
    logic [CNT_W-1:0]  rd_cnt, cnt_nxt;

    logic              aligned;
    logic [ADDR_W-1:0] cpu_word;
    logic              cpu_cand;
    logic              grant_cpu;
    logic              grant_upg;
    logic              capture;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_adr;
    logic [DATA_W-1:0] buf_dat;

    logic              unused_addr_hi;

    assign aligned        = (cpu_addr[1:0] == 2'b00);
    assign cpu_word       = cpu_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

    // In the rvalid cycle the MEM stage still presents the request it has just
    // been answered for; it must not be granted a second time.
    assign cpu_cand = cpu_req & aligned & ~upg_active & ~cpu_rvalid;

    dmem_arb_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .wen   (upg_wen),
        .wadr  (upg_adr),
        .wdat  (upg_dat),
        .drain (grant_upg),
        .full  (buf_full),
        .adr   (buf_adr),
        .dat   (buf_dat),
        .ovf   (upg_ovf)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = rd_cnt;
        grant_cpu = 1'b0;
        grant_upg = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_cand && buf_full) begin
                    grant_upg = (last_grant == REQ_CPU);
                    grant_cpu = (last_grant == REQ_UPG);
                end else begin
                    grant_cpu = cpu_cand;
                    grant_upg = buf_full;
                end
                if (grant_cpu || grant_upg) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_req_p1 == REQ_CPU && !mem_we) begin
                    state_nxt = RDWAIT;
                    cnt_nxt   = CNT_W'(RD_LAT);
                end else begin
                    state_nxt = IDLE;
                end
            end
            RDWAIT: begin
                cnt_nxt = rd_cnt - 1'b1;
                if (rd_cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cpu_stall    = cpu_req & aligned & ~(grant_cpu & cpu_we) & ~cpu_rvalid;
    assign cpu_misalign = cpu_req & ~aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rd_cnt <= cnt_nxt;
        end
    end

    // ---- issue stage: registered memory command ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            last_grant   <= REQ_CPU;
            issue_req_p1 <= REQ_CPU;
        end else begin
            mem_en <= grant_cpu | grant_upg;
            mem_we <= 1'b0;
            if (grant_cpu) begin
                mem_we       <= cpu_we;
                mem_addr     <= cpu_word;
                mem_wdata    <= cpu_wdata;
                last_grant   <= REQ_CPU;
                issue_req_p1 <= REQ_CPU;
            end else if (grant_upg) begin
                mem_we       <= 1'b1;
                mem_addr     <= buf_adr;
                mem_wdata    <= buf_dat;
                last_grant   <= REQ_UPG;
                issue_req_p1 <= REQ_UPG;
            end
        end
    end

    // ---- read return stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= capture;
            if (capture) begin
                cpu_rdata <= mem_dout;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic conflict;

    assign conflict = (state == IDLE) & cpu_cand & buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cyc <= '0;
            stat_conflicts <= '0;
        end else begin
            if (cpu_stall && stat_stall_cyc != '1) begin
                stat_stall_cyc <= stat_stall_cyc + 1'b1;
            end
            if (conflict && stat_conflicts != '1) begin
                stat_conflicts <= stat_conflicts + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random
// traffic, all checked against a cycle-count reference model and a word array.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_misalign;
    logic              upg_active = 1'b0;
    logic              upg_wen = 1'b0;
    logic [ADDR_W-1:0] upg_adr = '0;
    logic [DATA_W-1:0] upg_dat = '0;
    logic              upg_ovf;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_dout;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stat_stall_cyc;
    logic [15:0]       stat_conflicts;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_misalign (cpu_misalign),
        .upg_active   (upg_active),
        .upg_wen      (upg_wen),
        .upg_adr      (upg_adr),
        .upg_dat      (upg_dat),
        .upg_ovf      (upg_ovf),
`ifdef DMEM_ARB_STATS_EN
        .stat_stall_cyc (stat_stall_cyc),
        .stat_conflicts (stat_conflicts),
`endif
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_dout     (mem_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // 16-word BRAM with one cycle read latency, reloaded on every reset.
    logic [DATA_W-1:0] bram [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) bram[i] <= init_word(i);
            mem_dout <= '0;
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr[3:0]] <= mem_wdata;
            else        mem_dout <= bram[mem_addr[3:0]];
        end
    end

    // Reference model: arbiter availability as a cycle number, plus the
    // expected memory command, read return, loader slot and a shadow memory.
    int                cyc = 0;
    int                free_cyc = 0;
    int                rv_cyc = -1;
    logic [DATA_W-1:0] rv_data = '0;
    logic              exp_en = 1'b0;
    logic              exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic              last_upg = 1'b0;
    logic              m_full = 1'b0;
    logic [ADDR_W-1:0] m_adr = '0;
    logic [DATA_W-1:0] m_dat = '0;
    logic              m_ovf = 1'b0;
    logic [DATA_W-1:0] ref_mem [0:15];

    always @(negedge clk) begin
        logic              idle, rv, al, cpu_c, upg_c, g_cpu, g_upg;
        logic [ADDR_W-1:0] wa;
        idle = (cyc >= free_cyc);
        rv   = (cyc == rv_cyc);
        chk("mem_en", mem_en, exp_en);
        if (exp_en) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        chk("rvalid", cpu_rvalid, rv);
        if (rv) chk("rdata", cpu_rdata, rv_data);
        chk("ovf", upg_ovf, m_ovf);

        al    = (cpu_addr[1:0] == 2'b00);
        cpu_c = idle && cpu_req && al && !upg_active && !rv;
        upg_c = idle && m_full;
        g_upg = upg_c && (!cpu_c || !last_upg);
        g_cpu = cpu_c && !g_upg;
        wa    = cpu_addr[ADDR_W+1:2];

        if (!rst) begin
            chk("stall", cpu_stall, cpu_req && al && !(g_cpu && cpu_we) && !rv);
            chk("misalign", cpu_misalign, cpu_req && !al);
        end

        if (rst) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            free_cyc = cyc + 1;
            rv_cyc   = -1;
            exp_en   = 1'b0;
            last_upg = 1'b0;
            m_full   = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            exp_en = g_cpu || g_upg;
            if (g_upg) begin
                exp_we    = 1'b1;
                exp_addr  = m_adr;
                exp_wdata = m_dat;
                ref_mem[m_adr[3:0]] = m_dat;
                free_cyc  = cyc + 2;
                last_upg  = 1'b1;
            end else if (g_cpu) begin
                exp_we    = cpu_we;
                exp_addr  = wa;
                exp_wdata = cpu_wdata;
                last_upg  = 1'b0;
                if (cpu_we) begin
                    ref_mem[wa[3:0]] = cpu_wdata;
                    free_cyc = cyc + 2;
                end else begin
                    free_cyc = cyc + 2 + int'(RD_LAT);
                    rv_cyc   = cyc + 2 + int'(RD_LAT);
                    rv_data  = ref_mem[wa[3:0]];
                end
            end
            if (upg_wen) begin
                if (!m_full || g_upg) begin
                    m_full = 1'b1;
                    m_adr  = upg_adr;
                    m_dat  = upg_dat;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (g_upg) begin
                m_full = 1'b0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        cpu_req = 1'b0;
        upg_wen = 1'b0;
        upg_active = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int cnt_a, cnt_b;
        logic held;
        int unsigned word, mis;

        // Reset state
        step();
        @(negedge clk);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_misalign", cpu_misalign, 0);
        chk("rst_ovf", upg_ovf, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        step();
        rst = 1'b0;

        // First access: read of byte 0x10 (word 4)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk); chk("t1_stall_n0", cpu_stall, 1);
        step();
        @(negedge clk); chk("t1_en_n1", mem_en, 1); chk("t1_addr_n1", mem_addr, 4);
        chk("t1_stall_n1", cpu_stall, 1);
        step();
        @(negedge clk); chk("t1_stall_n2", cpu_stall, 1);
        step();
        @(negedge clk); chk("t1_rvalid_n3", cpu_rvalid, 1);
        chk("t1_rdata_n3", cpu_rdata, 32'hDEAD_BEEF); chk("t1_stall_n3", cpu_stall, 0);
        step();
        quiet(3);

        // Misaligned request is dropped without stalling
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h13;
        @(negedge clk); chk("t5_misalign", cpu_misalign, 1); chk("t5_stall", cpu_stall, 0);
        step();
        cpu_req = 1'b0;
        @(negedge clk); chk("t5_no_en", mem_en, 0);
        quiet(3);

        // Conflict: loader wins first, then CPU wins the repeated conflict
        upg_wen = 1'b1; upg_adr = 5; upg_dat = 32'hA5;
        step();
        upg_wen = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
        @(negedge clk); chk("t2_cpu_wait", cpu_stall, 1);
        step();
        upg_wen = 1'b1; upg_adr = 6; upg_dat = 32'h66;
        @(negedge clk); chk("t2_upg_addr", mem_addr, 5); chk("t2_upg_dat", mem_wdata, 32'hA5);
        step();
        upg_wen = 1'b0;
        @(negedge clk); chk("t2_cpu_grant", cpu_stall, 0);
        step();
        cpu_req = 1'b0;
        @(negedge clk); chk("t2_cpu_addr", mem_addr, 8); chk("t2_cpu_dat", mem_wdata, 32'h1234);
        step();
        step();
        @(negedge clk); chk("t2_upg2_addr", mem_addr, 6); chk("t2_upg2_we", mem_we, 1);
        quiet(3);

        // Lockout: loader owns the memory while the CPU waits
        cnt_a = 0; cnt_b = 0;
        upg_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h77;
        for (int i = 0; i < 20; i++) begin
            upg_wen = (i == 2 || i == 8 || i == 14);
            upg_adr = ADDR_W'(10 + i / 6);
            upg_dat = 32'hC000 + 32'(i);
            @(negedge clk);
            if (cpu_stall) cnt_a++;
            if (mem_en && mem_we) cnt_b++;
            step();
        end
        chk("t3_stall_cycles", cnt_a, 20);
        chk("t3_mem_writes", cnt_b, 3);
        quiet(3);

        // Overflow: two loader writes while a CPU read is outstanding
        chk("t4_ovf_before", upg_ovf, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        step();
        upg_wen = 1'b1; upg_adr = 12; upg_dat = 32'h1111;
        step();
        upg_wen = 1'b1; upg_adr = 13; upg_dat = 32'h2222;
        step();
        upg_wen = 1'b0;
        step();
        cpu_req = 1'b0;
        @(negedge clk); chk("t4_ovf_set", upg_ovf, 1);
        quiet(4);

        // Random traffic; the CPU holds its request while stalled
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(cpu_req && held)) begin
                word      = $urandom_range(0, 15);
                mis       = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = ($urandom_range(0, 1) == 1);
                cpu_addr  = (32'(word) << 2) | 32'(mis);
                cpu_wdata = $urandom;
            end
            upg_wen = ($urandom_range(0, 6) == 0);
            upg_adr = ADDR_W'($urandom_range(0, 15));
            upg_dat = $urandom;
            if ($urandom_range(0, 40) == 0) upg_active = !upg_active;
            @(negedge clk);
            held = cpu_stall;
        end
        step();
        quiet(8);
        chk("t4_ovf_sticky", upg_ovf, 1);

        // Reset during a read wait
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        step();
        upg_wen = 1'b1; upg_adr = 3; upg_dat = 32'h3333;
        step();
        upg_wen = 1'b0; cpu_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_rvalid) cnt_a++;
            if (mem_en) cnt_b++;
            step();
        end
        chk("t6_no_rvalid", cnt_a, 0);
        chk("t6_no_mem_en", cnt_b, 0);
        chk("t6_ovf_clear", upg_ovf, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
